// File: rtl/frame_render_pkg.sv
// frame_render_pkg: shared types and default geometry for the frame renderer
// and the ping-pong buffer instantiation that sits downstream of it.
//   render_state_t : renderer FSM state encoding
//   GRID_W_D/GRID_H_D/ADDR_W_D : default tile grid size and address width
package frame_render_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CLEAR  = 2'd1,
      DRAW   = 2'd2,
      UPDATE = 2'd3
   } render_state_t;

   localparam int GRID_W_D = 32;
   localparam int GRID_H_D = 24;
   localparam int ADDR_W_D = 10;

endpackage

// File: rtl/frame_renderer_sprite_mover.sv
// sprite_mover: holds the sprite position (px, py) and its per-axis direction,
// and applies one diagonal step with edge bounce each time i_step is high.
//   i_clk  : clock
//   i_rst  : asynchronous active-high reset (position 0,0; moving +x,+y)
//   i_step : apply one movement step at this edge
//   o_px   : sprite left column
//   o_py   : sprite top row
module sprite_mover #(
   parameter int GRID_W = 32,
   parameter int GRID_H = 24,
   parameter int SPR_W  = 4,
   parameter int SPR_H  = 3,
   parameter int PX_W   = $clog2(GRID_W + 1),
   parameter int PY_W   = $clog2(GRID_H + 1)
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_step,
   output logic [PX_W-1:0] o_px,
   output logic [PY_W-1:0] o_py
);

   localparam logic [PX_W-1:0] X_MAX   = PX_W'(GRID_W - SPR_W);
   localparam logic [PY_W-1:0] Y_MAX   = PY_W'(GRID_H - SPR_H);
   // A sprite as wide (tall) as the grid has nowhere to go on that axis.
   localparam bit              X_FIXED = (GRID_W == SPR_W);
   localparam bit              Y_FIXED = (GRID_H == SPR_H);

   logic [PX_W-1:0] r_px;
   logic [PY_W-1:0] r_py;
   logic            r_dx;   // 1 = moving +x, 0 = moving -x
   logic            r_dy;   // 1 = moving +y, 0 = moving -y

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_px <= '0;
         r_py <= '0;
         r_dx <= 1'b1;
         r_dy <= 1'b1;
      end else if (i_step) begin
         if (!X_FIXED) begin
            // Bouncing reverses direction and moves one cell back in the
            // same step, so the sprite never lingers on an edge.
            if (r_dx && (r_px == X_MAX)) begin
               r_dx <= 1'b0;
               r_px <= r_px - PX_W'(1);
            end else if (!r_dx && (r_px == '0)) begin
               r_dx <= 1'b1;
               r_px <= r_px + PX_W'(1);
            end else if (r_dx) begin
               r_px <= r_px + PX_W'(1);
            end else begin
               r_px <= r_px - PX_W'(1);
            end
         end
         if (!Y_FIXED) begin
            if (r_dy && (r_py == Y_MAX)) begin
               r_dy <= 1'b0;
               r_py <= r_py - PY_W'(1);
            end else if (!r_dy && (r_py == '0)) begin
               r_dy <= 1'b1;
               r_py <= r_py + PY_W'(1);
            end else if (r_dy) begin
               r_py <= r_py + PY_W'(1);
            end else begin
               r_py <= r_py - PY_W'(1);
            end
         end
      end
   end

   assign o_px = r_px;
   assign o_py = r_py;

endmodule

// File: rtl/frame_renderer.sv
// frame_renderer: on each frameStart repaints the whole back buffer of the
// ping-pong frame RAM: clear every cell to BG_COLOR, draw a solid sprite in
// FG_COLOR, then advance the sprite one diagonal step.
//   vgaclk     : pixel clock
//   rst        : asynchronous active-high reset
//   frameStart : one-cycle frame pulse (same pulse that swaps the buffers)
//   we         : buffer write strobe
//   wrAddr     : cell address y*GRID_W + x
//   wrData     : cell colour
//   busy       : high in CLEAR, DRAW and UPDATE
//   overrun    : sticky, set when frameStart lands in CLEAR or DRAW
//   o_state    : current FSM state, for observation
// Write port handshake: there is no back-pressure; every cycle with we=1
// carries one valid (wrAddr, wrData) that the buffer must accept.
// All outputs are registered and computed from the next-state values, so a
// frameStart in cycle t gives the first write (address 0) in cycle t+1.
module frame_renderer
   import frame_render_pkg::*;
#(
   parameter int         GRID_W   = GRID_W_D,
   parameter int         GRID_H   = GRID_H_D,
   parameter int         ADDR_W   = ADDR_W_D,
   parameter int         SPR_W    = 4,
   parameter int         SPR_H    = 3,
   parameter logic [7:0] BG_COLOR = 8'h00,
   parameter logic [7:0] FG_COLOR = 8'hE0
) (
   input  logic              vgaclk,
   input  logic              rst,
   input  logic              frameStart,
   output logic              we,
   output logic [ADDR_W-1:0] wrAddr,
   output logic [7:0]        wrData,
   output logic              busy,
   output logic              overrun,
   output render_state_t     o_state
);

   localparam int PX_W = $clog2(GRID_W + 1);
   localparam int PY_W = $clog2(GRID_H + 1);
   localparam int COL_W = $clog2(SPR_W + 1);
   localparam int ROW_W = $clog2(SPR_H + 1);
   localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(GRID_W * GRID_H - 1);
   localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(SPR_W - 1);
   localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(SPR_H - 1);

   render_state_t     r_state;
   logic [ADDR_W-1:0] r_cnt;
   logic [COL_W-1:0]  r_col;
   logic [ROW_W-1:0]  r_row;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [7:0]        r_data;
   logic              r_busy;
   logic              r_overrun;

   render_state_t     w_next_state;
   logic [ADDR_W-1:0] w_next_cnt;
   logic [COL_W-1:0]  w_next_col;
   logic [ROW_W-1:0]  w_next_row;
   logic              w_next_we;
   logic [ADDR_W-1:0] w_next_addr;
   logic [7:0]        w_next_data;
   logic              w_set_ovr;
   logic              w_step;
   logic [PX_W-1:0]   w_px;
   logic [PY_W-1:0]   w_py;

   sprite_mover #(
      .GRID_W (GRID_W),
      .GRID_H (GRID_H),
      .SPR_W  (SPR_W),
      .SPR_H  (SPR_H),
      .PX_W   (PX_W),
      .PY_W   (PY_W)
   ) u_mover (
      .i_clk  (vgaclk),
      .i_rst  (rst),
      .i_step (w_step),
      .o_px   (w_px),
      .o_py   (w_py)
   );

   always_comb begin
      w_next_state = r_state;
      w_next_cnt   = r_cnt;
      w_next_col   = r_col;
      w_next_row   = r_row;
      w_set_ovr    = 1'b0;
      w_step       = 1'b0;

      case (r_state)
         IDLE: begin
            if (frameStart) begin
               w_next_state = CLEAR;
               w_next_cnt   = '0;
            end
         end
         CLEAR: begin
            if (frameStart) begin
               // Buffers just swapped under us: restart in the new back buffer.
               w_next_state = CLEAR;
               w_next_cnt   = '0;
               w_set_ovr    = 1'b1;
            end else if (r_cnt == LAST_CELL) begin
               w_next_state = DRAW;
               w_next_col   = '0;
               w_next_row   = '0;
            end else begin
               w_next_cnt = r_cnt + ADDR_W'(1);
            end
         end
         DRAW: begin
            if (frameStart) begin
               w_next_state = CLEAR;
               w_next_cnt   = '0;
               w_set_ovr    = 1'b1;
            end else if (r_col == LAST_COL) begin
               w_next_col = '0;
               if (r_row == LAST_ROW) begin
                  w_next_state = UPDATE;
               end else begin
                  w_next_row = r_row + ROW_W'(1);
               end
            end else begin
               w_next_col = r_col + COL_W'(1);
            end
         end
         UPDATE: begin
            // The step always commits; a coincident frameStart is on time.
            w_step = 1'b1;
            if (frameStart) begin
               w_next_state = CLEAR;
               w_next_cnt   = '0;
            end else begin
               w_next_state = IDLE;
            end
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase

      w_next_we   = 1'b0;
      w_next_addr = '0;
      w_next_data = '0;
      if (w_next_state == CLEAR) begin
         w_next_we   = 1'b1;
         w_next_addr = w_next_cnt;
         w_next_data = BG_COLOR;
      end else if (w_next_state == DRAW) begin
         w_next_we   = 1'b1;
         w_next_addr = (ADDR_W'(w_py) + ADDR_W'(w_next_row)) * ADDR_W'(GRID_W)
                       + ADDR_W'(w_px) + ADDR_W'(w_next_col);
         w_next_data = FG_COLOR;
      end
   end

   always_ff @(posedge vgaclk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_col     <= '0;
         r_row     <= '0;
         r_we      <= 1'b0;
         r_addr    <= '0;
         r_data    <= '0;
         r_busy    <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_state   <= w_next_state;
         r_cnt     <= w_next_cnt;
         r_col     <= w_next_col;
         r_row     <= w_next_row;
         r_we      <= w_next_we;
         r_addr    <= w_next_addr;
         r_data    <= w_next_data;
         r_busy    <= (w_next_state != IDLE);
         r_overrun <= r_overrun | w_set_ovr;
      end
   end

   assign we      = r_we;
   assign wrAddr  = r_addr;
   assign wrData  = r_data;
   assign busy    = r_busy;
   assign overrun = r_overrun;
   assign o_state = r_state;

endmodule

// File: tb/tb_frame_renderer.sv
module tb_frame_renderer;
  import frame_render_pkg::*;

  localparam int GW = 32;
  localparam int GH = 24;
  localparam int AW = 10;
  localparam int SW = 4;
  localparam int SH = 3;
  localparam int N  = GW * GH;
  localparam int S  = SW * SH;

  logic          vgaclk = 1'b0;
  logic          rst;
  logic          frameStart;
  logic          we;
  logic [AW-1:0] wrAddr;
  logic [7:0]    wrData;
  logic          busy;
  logic          overrun;
  render_state_t dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  logic [AW-1:0] cap_addr[$];
  logic [7:0]    cap_data[$];
  logic [AW-1:0] exp_q[$];
  int            busy_cycles;
  bit            cap_timeout;

  // clock / reset block
  always #5 vgaclk = ~vgaclk;

  frame_renderer #(
    .GRID_W(GW), .GRID_H(GH), .ADDR_W(AW), .SPR_W(SW), .SPR_H(SH),
    .BG_COLOR(8'h00), .FG_COLOR(8'hE0)
  ) dut (
    .vgaclk(vgaclk), .rst(rst), .frameStart(frameStart),
    .we(we), .wrAddr(wrAddr), .wrData(wrData),
    .busy(busy), .overrun(overrun), .o_state(dbg_state)
  );

  // Sprite position for frame f counted from reset (frame 0 at 0,0):
  // x bounces at 28 (frame 28), y bounces at 21 (frame 21).
  function automatic int pos_x(input int f);
    if (f <= 28) return f;
    return 56 - f;
  endfunction

  function automatic int pos_y(input int f);
    if (f <= 21) return f;
    return 42 - f;
  endfunction

  task automatic build_exp(input int x, input int y);
    exp_q.delete();
    for (int r = 0; r < SH; r++)
      for (int c = 0; c < SW; c++)
        exp_q.push_back(AW'((y + r) * GW + x + c));
  endtask

  // driver: record every write from the current sample until busy drops
  task automatic capture_rest();
    cap_addr.delete();
    cap_data.delete();
    busy_cycles = 0;
    cap_timeout = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (!busy) begin
        cap_timeout = 1'b0;
        break;
      end
      busy_cycles++;
      if (we) begin
        cap_addr.push_back(wrAddr);
        cap_data.push_back(wrData);
      end
      @(negedge vgaclk);
    end
  endtask

  task automatic capture_frame();
    frameStart = 1'b1;
    @(negedge vgaclk);
    frameStart = 1'b0;
    capture_rest();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    frameStart = 1'b0;
    repeat (3) @(negedge vgaclk);
    n_cmp++; if ({we, busy, overrun} !== 3'b000) begin n_err++; $display("FAIL reset_ctrl: got %b expected 000", {we, busy, overrun}); end
    n_cmp++; if (wrAddr !== '0) begin n_err++; $display("FAIL reset_addr: got %0d expected 0", wrAddr); end
    n_cmp++; if (wrData !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h expected 00", wrData); end
    rst = 1'b0;
    repeat (2) @(negedge vgaclk);
    n_cmp++; if ({we, busy} !== 2'b00) begin n_err++; $display("FAIL idle_after_reset: got %b expected 00", {we, busy}); end
    n_cmp++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL idle_state: got %0d expected %0d", dbg_state, IDLE); end
  endtask

  task automatic test_first_frame();
    build_exp(0, 0);
    capture_frame();
    n_cmp++; if (cap_timeout !== 1'b0) begin n_err++; $display("FAIL f0_timeout: busy never fell"); end
    n_cmp++; if (busy_cycles != N + S + 1) begin n_err++; $display("FAIL f0_busy_len: got %0d expected %0d", busy_cycles, N + S + 1); end
    n_cmp++; if (cap_addr.size() != N + S) begin n_err++; $display("FAIL f0_writes: got %0d expected %0d", cap_addr.size(), N + S); end
    if (cap_addr.size() == N + S) begin
      for (int k = 0; k < N; k++) begin
        n_cmp++;
        if ({cap_addr[k], cap_data[k]} !== {AW'(k), 8'h00}) begin
          n_err++; $display("FAIL f0_clear[%0d]: got %0d/%h expected %0d/00", k, cap_addr[k], cap_data[k], k);
        end
      end
      for (int k = 0; k < S; k++) begin
        n_cmp++;
        if ({cap_addr[N+k], cap_data[N+k]} !== {exp_q[k], 8'hE0}) begin
          n_err++; $display("FAIL f0_sprite[%0d]: got %0d/%h expected %0d/e0", k, cap_addr[N+k], cap_data[N+k], exp_q[k]);
        end
      end
    end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL f0_overrun: got %b expected 0", overrun); end
  endtask

  task automatic test_second_frame();
    build_exp(1, 1);
    capture_frame();
    n_cmp++; if (busy_cycles != N + S + 1) begin n_err++; $display("FAIL f1_busy_len: got %0d expected %0d", busy_cycles, N + S + 1); end
    n_cmp++; if (cap_addr.size() != N + S) begin n_err++; $display("FAIL f1_writes: got %0d expected %0d", cap_addr.size(), N + S); end
    if (cap_addr.size() == N + S) begin
      n_cmp++; if (cap_addr[N] !== AW'(33)) begin n_err++; $display("FAIL f1_sprite_start: got %0d expected 33", cap_addr[N]); end
      for (int k = 0; k < S; k++) begin
        n_cmp++;
        if ({cap_addr[N+k], cap_data[N+k]} !== {exp_q[k], 8'hE0}) begin
          n_err++; $display("FAIL f1_sprite[%0d]: got %0d/%h expected %0d/e0", k, cap_addr[N+k], cap_data[N+k], exp_q[k]);
        end
      end
    end
  endtask

  task automatic test_bounce();
    int first_exp;
    for (int f = 2; f < 30; f++) begin
      build_exp(pos_x(f), pos_y(f));
      capture_frame();
      n_cmp++; if (busy_cycles != N + S + 1) begin n_err++; $display("FAIL bounce_busy f%0d: got %0d expected %0d", f, busy_cycles, N + S + 1); end
      n_cmp++; if (cap_addr.size() != N + S) begin n_err++; $display("FAIL bounce_writes f%0d: got %0d expected %0d", f, cap_addr.size(), N + S); end
      if (cap_addr.size() == N + S) begin
        for (int k = 0; k < S; k++) begin
          n_cmp++;
          if ({cap_addr[N+k], cap_data[N+k]} !== {exp_q[k], 8'hE0}) begin
            n_err++; $display("FAIL bounce_sprite f%0d[%0d]: got %0d/%h expected %0d/e0", f, k, cap_addr[N+k], cap_data[N+k], exp_q[k]);
          end
        end
        // hand-computed first sprite cell around the two bounces
        first_exp = -1;
        case (f)
          21: first_exp = 693;  // (21,21)
          22: first_exp = 662;  // (22,20)
          28: first_exp = 476;  // (28,14)
          29: first_exp = 443;  // (27,13)
          default: first_exp = -1;
        endcase
        if (first_exp >= 0) begin
          n_cmp++;
          if (cap_addr[N] !== AW'(first_exp)) begin
            n_err++; $display("FAIL bounce_edge f%0d: got %0d expected %0d", f, cap_addr[N], first_exp);
          end
        end
      end
    end
  endtask

  task automatic test_boundary_pulse();
    bit found;
    int n_spr;
    // frame 30 draws at (26,12); inject frameStart in its UPDATE cycle
    build_exp(pos_x(30), pos_y(30));
    frameStart = 1'b1;
    @(negedge vgaclk);
    frameStart = 1'b0;
    found = 1'b0;
    n_spr = 0;
    for (int i = 0; i < 2000; i++) begin
      if (busy && !we) begin
        found = 1'b1;
        break;
      end
      if (we && wrData == 8'hE0) begin
        n_cmp++;
        if (n_spr >= S || wrAddr !== exp_q[n_spr]) begin
          n_err++; $display("FAIL f30_sprite[%0d]: got %0d expected %0d", n_spr, wrAddr, (n_spr < S) ? exp_q[n_spr] : '0);
        end
        n_spr++;
      end
      @(negedge vgaclk);
    end
    n_cmp++; if (!found) begin n_err++; $display("FAIL update_wait: UPDATE cycle not seen"); end
    n_cmp++; if (n_spr != S) begin n_err++; $display("FAIL f30_sprite_count: got %0d expected %0d", n_spr, S); end
    frameStart = 1'b1;
    @(negedge vgaclk);
    frameStart = 1'b0;
    n_cmp++; if ({we, busy, overrun} !== 3'b110) begin n_err++; $display("FAIL boundary_ctrl: got %b expected 110", {we, busy, overrun}); end
    n_cmp++; if (wrAddr !== '0) begin n_err++; $display("FAIL boundary_addr: got %0d expected 0", wrAddr); end
    // the update committed, so this frame is frame 31 at (25,11)
    build_exp(pos_x(31), pos_y(31));
    capture_rest();
    n_cmp++; if (busy_cycles != N + S + 1) begin n_err++; $display("FAIL boundary_busy: got %0d expected %0d", busy_cycles, N + S + 1); end
    n_cmp++; if (cap_addr.size() != N + S) begin n_err++; $display("FAIL boundary_writes: got %0d expected %0d", cap_addr.size(), N + S); end
    if (cap_addr.size() == N + S) begin
      for (int k = 0; k < S; k++) begin
        n_cmp++;
        if ({cap_addr[N+k], cap_data[N+k]} !== {exp_q[k], 8'hE0}) begin
          n_err++; $display("FAIL boundary_sprite[%0d]: got %0d/%h expected %0d/e0", k, cap_addr[N+k], cap_data[N+k], exp_q[k]);
        end
      end
    end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL boundary_overrun: got %b expected 0", overrun); end
  endtask

  task automatic test_overrun();
    bit found;
    frameStart = 1'b1;
    @(negedge vgaclk);
    frameStart = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (we && wrAddr == AW'(400)) begin
        found = 1'b1;
        break;
      end
      @(negedge vgaclk);
    end
    n_cmp++; if (!found) begin n_err++; $display("FAIL overrun_wait: CLEAR cell 400 not seen"); end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL overrun_pre: got %b expected 0", overrun); end
    frameStart = 1'b1;
    @(negedge vgaclk);
    frameStart = 1'b0;
    n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL overrun_set: got %b expected 1", overrun); end
    n_cmp++; if ({we, wrAddr, wrData} !== {1'b1, AW'(0), 8'h00}) begin n_err++; $display("FAIL overrun_restart: got we=%b addr=%0d data=%h expected 1/0/00", we, wrAddr, wrData); end
    // aborted render must not move the sprite: still frame 32 position
    build_exp(pos_x(32), pos_y(32));
    capture_rest();
    n_cmp++; if (busy_cycles != N + S + 1) begin n_err++; $display("FAIL overrun_busy: got %0d expected %0d", busy_cycles, N + S + 1); end
    n_cmp++; if (cap_addr.size() != N + S) begin n_err++; $display("FAIL overrun_writes: got %0d expected %0d", cap_addr.size(), N + S); end
    if (cap_addr.size() == N + S) begin
      for (int k = 0; k < S; k++) begin
        n_cmp++;
        if ({cap_addr[N+k], cap_data[N+k]} !== {exp_q[k], 8'hE0}) begin
          n_err++; $display("FAIL overrun_sprite[%0d]: got %0d/%h expected %0d/e0", k, cap_addr[N+k], cap_data[N+k], exp_q[k]);
        end
      end
    end
    build_exp(pos_x(33), pos_y(33));
    capture_frame();
    n_cmp++; if (cap_addr.size() != N + S) begin n_err++; $display("FAIL f33_writes: got %0d expected %0d", cap_addr.size(), N + S); end
    if (cap_addr.size() == N + S) begin
      for (int k = 0; k < S; k++) begin
        n_cmp++;
        if ({cap_addr[N+k], cap_data[N+k]} !== {exp_q[k], 8'hE0}) begin
          n_err++; $display("FAIL f33_sprite[%0d]: got %0d/%h expected %0d/e0", k, cap_addr[N+k], cap_data[N+k], exp_q[k]);
        end
      end
    end
    n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL overrun_sticky: got %b expected 1", overrun); end
  endtask

  task automatic test_async_reset();
    bit found;
    int stray;
    frameStart = 1'b1;
    @(negedge vgaclk);
    frameStart = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (we && wrData == 8'hE0) begin
        found = 1'b1;
        break;
      end
      @(negedge vgaclk);
    end
    n_cmp++; if (!found) begin n_err++; $display("FAIL areset_wait: DRAW not seen"); end
    #2;
    rst = 1'b1;
    #1;
    // still 2 time units before the next rising edge
    n_cmp++; if ({we, busy, overrun} !== 3'b000) begin n_err++; $display("FAIL areset_ctrl: got %b expected 000", {we, busy, overrun}); end
    n_cmp++; if ({wrAddr, wrData} !== {AW'(0), 8'h00}) begin n_err++; $display("FAIL areset_bus: got %0d/%h expected 0/00", wrAddr, wrData); end
    @(negedge vgaclk);
    rst = 1'b0;
    stray = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge vgaclk);
      if (we || busy) stray++;
    end
    n_cmp++; if (stray != 0) begin n_err++; $display("FAIL areset_quiet: got %0d active cycles expected 0", stray); end
    build_exp(0, 0);
    capture_frame();
    n_cmp++; if (cap_addr.size() != N + S) begin n_err++; $display("FAIL areset_f0_writes: got %0d expected %0d", cap_addr.size(), N + S); end
    if (cap_addr.size() == N + S) begin
      for (int k = 0; k < S; k++) begin
        n_cmp++;
        if ({cap_addr[N+k], cap_data[N+k]} !== {exp_q[k], 8'hE0}) begin
          n_err++; $display("FAIL areset_f0_sprite[%0d]: got %0d/%h expected %0d/e0", k, cap_addr[N+k], cap_data[N+k], exp_q[k]);
        end
      end
    end
    build_exp(1, 1);
    capture_frame();
    n_cmp++; if (cap_addr.size() != N + S) begin n_err++; $display("FAIL areset_f1_writes: got %0d expected %0d", cap_addr.size(), N + S); end
    if (cap_addr.size() == N + S) begin
      for (int k = 0; k < S; k++) begin
        n_cmp++;
        if ({cap_addr[N+k], cap_data[N+k]} !== {exp_q[k], 8'hE0}) begin
          n_err++; $display("FAIL areset_f1_sprite[%0d]: got %0d/%h expected %0d/e0", k, cap_addr[N+k], cap_data[N+k], exp_q[k]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    frameStart = 1'b0;
    @(negedge vgaclk);
    test_reset();
    test_first_frame();
    test_second_frame();
    test_bounce();
    test_boundary_pulse();
    test_overrun();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/frame_renderer.md
# frame_renderer

Animation writer that feeds the ping-pong frame buffer's write port. On every frame-start pulse it redraws the whole back buffer:
- first it clears all cells of a GRID_W×GRID_H tile grid to a background colour;
- then it draws a solid SPR_W×SPR_H sprite at the current position;
- then it advances the sprite one cell diagonally, bouncing off the grid edges.

It sits directly upstream of the ping-pong RAM and shares its clock and frame-start pulse. The buffers swap every frame, so the writer repaints every cell every frame.

## Interface
- GRID_W, 32: grid width in cells
- GRID_H, 24: grid height in cells; GRID_W*GRID_H is the buffer depth (768)
- ADDR_W, 10: write address width; must satisfy 2**ADDR_W ≥ GRID_W*GRID_H
- SPR_W, 4: sprite width in cells; 1 ≤ SPR_W ≤ GRID_W
- SPR_H, 3: sprite height in cells; 1 ≤ SPR_H ≤ GRID_H
- BG_COLOR, 8'h00: clear colour
- FG_COLOR, 8'hE0: sprite colour
- vgaclk  in  1  pixel clock; the only clock
- rst  in  1  reset, asynchronous, active-high
- frameStart  in  1  one-cycle pulse at hc==0 && vc==0, the same pulse the buffer uses to swap
- we  out  1  write strobe to the buffer
- wrAddr  out  ADDR_W  cell address, y*GRID_W + x
- wrData  out  8  cell colour
- busy  out  1  high while a render is in progress (CLEAR, DRAW, UPDATE)
- overrun  out  1  sticky; set when frameStart arrives mid-render; cleared only by rst

## Operation
States: IDLE, CLEAR, DRAW, UPDATE.

- **IDLE**
  - we=0.
  - frameStart → CLEAR, with cell counter at 0.
- **CLEAR**
  - One write per cycle: wrAddr = counter 0 … GRID_W*GRID_H-1, wrData = BG_COLOR.
  - After the last cell → DRAW.
- **DRAW**
  - Row-major over the sprite: wrAddr = (py+r)*GRID_W + (px+c), for r in 0…SPR_H-1 and c in 0…SPR_W-1; wrData = FG_COLOR.
  - After the last cell → UPDATE.
- **UPDATE** (one cycle, we=0), applied per axis. Shown for x; y is identical with GRID_H/SPR_H/dy.
  - If dx=+1 and px==GRID_W-SPR_W: dx←-1, px←px-1.
  - If dx=-1 and px==0: dx←+1, px←px+1.
  - Otherwise px←px+dx.
  - If GRID_W==SPR_W: px stays 0 and dx is unchanged.
  - Then → IDLE.
- **frameStart during CLEAR or DRAW**
  - Abort the current render, set overrun, restart CLEAR at cell 0.
  - Position and velocity are unchanged.
- **frameStart during UPDATE**
  - The update commits, then go to CLEAR. overrun is not set.
- **Arithmetic**
  - Address math uses unsigned ADDR_W bits; no wrap is possible because the parameter constraints keep every address < GRID_W*GRID_H.
  - px/py use $clog2(GRID_W+1) and $clog2(GRID_H+1) bits.
  - Velocity is a 1-bit direction per axis.

## Timing
- **Registered outputs.** All outputs are registered.
- **Reset values.**
  - Outputs: we=0, wrAddr=0, wrData=0, busy=0, overrun=0.
  - State: IDLE; px=py=0; dx=dy=+1.
- **Start-of-frame latency.** frameStart high in cycle t → we=1 with wrAddr=0 in cycle t+1.
  - The buffer swaps at the edge ending cycle t, so every write lands in the new back buffer.
- **Render schedule.**
  - CLEAR writes occupy t+1 … t+N, where N=GRID_W*GRID_H.
  - DRAW occupies t+N+1 … t+N+S, where S=SPR_W*SPR_H.
  - UPDATE is at t+N+S+1; busy falls in t+N+S+2.
- **Frame budget.** N+S+1 cycles is far below the 420000-cycle 640×480 frame; overrun is a debug indicator only.
- **busy.** High for exactly the cycles in CLEAR, DRAW and UPDATE.
- **Reset mid-render.** Asynchronous: outputs drop to reset values immediately; no further writes occur until the next frameStart.

## Structure
- Package `frame_render_pkg` holds:
  - the state enum `render_state_t` (IDLE, CLEAR, DRAW, UPDATE);
  - default constants GRID_W_D=32, GRID_H_D=24, ADDR_W_D=10, shared with the buffer instantiation.
- Sub-module `sprite_mover` holds px/py/dx/dy and the bounce logic.
  - Its single `step` input is asserted in UPDATE.
  - It exposes px and py.
  - It is parameterised by GRID_W, GRID_H, SPR_W and SPR_H.
- The FSM, cell counters and address generation live in `frame_renderer`.

## Test plan
- **Reset then first frame:** rst, then a frameStart pulse.
  - 768 writes of 8'h00 at addrs 0…767.
  - Then 12 writes of 8'hE0 at addrs 0-3, 32-35, 64-67.
  - busy high for exactly 781 cycles.
- **Second frame:** sprite writes start at addr 33 (px=py=1).
- **Bounce:** 21 frames → py=21, sprite rows at addrs 672/704/736 + px.
  - The 22nd frame draws at py=20; dy is now -1.
  - x behaves the same: px=28 at frame 28, then 27.
- **Overrun:** frameStart injected at cycle 400 of CLEAR.
  - overrun=1 next cycle; wrAddr restarts at 0; the sprite position is unchanged on the following completed frame.
  - overrun stays 1 until rst.
- **Boundary pulse:** frameStart coincident with UPDATE.
  - Position advances, the new CLEAR starts at addr 0, overrun stays 0.
- **Async reset mid-DRAW:** rst asserted between clock edges.
  - we=0 without waiting for a clock edge, px=py=0, no writes until the next frameStart.
